// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read, issue and write-back signals of the scoreboarded register file.
interface reg_file_sb_if #(parameter int ADDR_W = 5, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] rs1_addr, rs2_addr, issue_rd, wb0_addr, wb1_addr;
  logic [DATA_W-1:0] rs1_value, rs2_value, wb0_data, wb1_data, a0_value;
  logic rs1_busy, rs2_busy, issue_valid, stall, wb0_en, wb1_en;
  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_rd, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, stall, a0_value
  );
  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, issue_rd, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, stall, a0_value
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register busy scoreboard, two write-back ports
// and optional write-to-read forwarding; x0 is hardwired to zero.
module reg_file_sb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  reg_file_sb_if.slave bus
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [N];
  logic [N-1:0] busy, clr, set, eff, busy_nxt;
  logic w0, w1, go;
  assign w0 = bus.wb0_en && bus.wb0_addr != '0;
  assign w1 = bus.wb1_en && bus.wb1_addr != '0;
  assign clr = (bus.wb0_en ? N'(1) << bus.wb0_addr : '0) | (bus.wb1_en ? N'(1) << bus.wb1_addr : '0);
  // A write-back landing this cycle releases its busy bit early when forwarding is on.
  assign eff = BYPASS != 0 ? busy & ~clr : busy;
  assign bus.stall = bus.issue_valid && (eff[bus.rs1_addr] || eff[bus.rs2_addr] || eff[bus.issue_rd]);
  assign go = bus.issue_valid && !bus.stall && bus.issue_rd != '0;
  assign set = go ? N'(1) << bus.issue_rd : '0;
  assign busy_nxt = ((busy & ~clr) | set) & ~N'(1);
  assign bus.rs1_busy = eff[bus.rs1_addr];
  assign bus.rs2_busy = eff[bus.rs2_addr];
  assign bus.rs1_value = bus.rs1_addr == '0 ? '0 :
    (BYPASS != 0 && w1 && bus.wb1_addr == bus.rs1_addr) ? bus.wb1_data :
    (BYPASS != 0 && w0 && bus.wb0_addr == bus.rs1_addr) ? bus.wb0_data : regs[bus.rs1_addr];
  assign bus.rs2_value = bus.rs2_addr == '0 ? '0 :
    (BYPASS != 0 && w1 && bus.wb1_addr == bus.rs2_addr) ? bus.wb1_data :
    (BYPASS != 0 && w0 && bus.wb0_addr == bus.rs2_addr) ? bus.wb0_data : regs[bus.rs2_addr];
  assign bus.a0_value = regs[10];
  // wb1 is written last so it wins a same-register collision.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (w0) regs[bus.wb0_addr] <= bus.wb0_data;
      if (w1) regs[bus.wb1_addr] <= bus.wb1_data;
      busy <= busy_nxt;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: table-driven directed checks of reg_file_sb (forwarding and non-forwarding builds).
module tb_reg_file_sb;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  reg_file_sb_if #(5, 32) bus ();
  reg_file_sb_if #(5, 32) nb ();
  reg_file_sb #(.ADDR_W(5), .DATA_W(32), .BYPASS(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  reg_file_sb #(.ADDR_W(5), .DATA_W(32), .BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .bus(nb.slave));
  assign nb.rs1_addr = bus.rs1_addr;
  assign nb.rs2_addr = bus.rs2_addr;
  assign nb.issue_valid = bus.issue_valid;
  assign nb.issue_rd = bus.issue_rd;
  assign nb.wb0_en = bus.wb0_en;
  assign nb.wb0_addr = bus.wb0_addr;
  assign nb.wb0_data = bus.wb0_data;
  assign nb.wb1_en = bus.wb1_en;
  assign nb.wb1_addr = bus.wb1_addr;
  assign nb.wb1_data = bus.wb1_data;
  typedef struct {
    logic [4:0] rs1, rs2;
    logic iv;
    logic [4:0] rd;
    logic w0e;
    logic [4:0] w0a;
    logic [31:0] w0d;
    logic w1e;
    logic [4:0] w1a;
    logic [31:0] w1d;
    logic [31:0] e_rs1v, e_rs2v;
    logic e_rs1b, e_rs2b, e_stall;
    logic [31:0] e_a0;
    logic chk_nb;
    logic [31:0] e_nb_rs1v;
    logic e_nb_stall;
  } vec_t;
  vec_t v [19];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    bus.rs1_addr = t.rs1; bus.rs2_addr = t.rs2; bus.issue_valid = t.iv; bus.issue_rd = t.rd;
    bus.wb0_en = t.w0e; bus.wb0_addr = t.w0a; bus.wb0_data = t.w0d;
    bus.wb1_en = t.w1e; bus.wb1_addr = t.w1a; bus.wb1_data = t.w1d;
  endtask
  task automatic check_all(input string p, input vec_t t);
    check({p, " rs1_value"}, bus.rs1_value, t.e_rs1v);
    check({p, " rs2_value"}, bus.rs2_value, t.e_rs2v);
    check({p, " rs1_busy"}, 32'(bus.rs1_busy), 32'(t.e_rs1b));
    check({p, " rs2_busy"}, 32'(bus.rs2_busy), 32'(t.e_rs2b));
    check({p, " stall"}, 32'(bus.stall), 32'(t.e_stall));
    check({p, " a0_value"}, bus.a0_value, t.e_a0);
  endtask
  function automatic vec_t mk(input logic [4:0] rs1, rs2, input logic iv, input logic [4:0] rd,
                              input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                              input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                              input logic [31:0] e_rs1v, e_rs2v, input logic e_rs1b, e_rs2b, e_stall,
                              input logic [31:0] e_a0);
    vec_t t;
    t = '{rs1, rs2, iv, rd, w0e, w0a, w0d, w1e, w1a, w1d, e_rs1v, e_rs2v, e_rs1b, e_rs2b, e_stall, e_a0, 1'b0, 32'h0, 1'b0};
    return t;
  endfunction
  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[0]  = idle;
    v[1]  = mk(5, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
    v[1].chk_nb = 1; v[1].e_nb_rs1v = 0; v[1].e_nb_stall = 0;
    v[2]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
    v[2].chk_nb = 1; v[2].e_nb_rs1v = 32'h1234; v[2].e_nb_stall = 0;
    v[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    v[4]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[6]  = mk(5, 0, 1, 7, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
    v[7]  = mk(0, 7, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v[8]  = mk(8, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v[9]  = mk(0, 7, 1, 8, 0, 0, 0, 1, 7, 32'hAA, 0, 32'hAA, 0, 0, 0, 0);
    v[9].chk_nb = 1; v[9].e_nb_rs1v = 0; v[9].e_nb_stall = 1;
    v[10] = mk(8, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAA, 1, 0, 0, 0);
    v[11] = mk(0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[12] = mk(3, 0, 0, 0, 1, 3, 32'h11, 1, 3, 32'h22, 32'h22, 0, 0, 0, 0, 0);
    v[13] = mk(3, 8, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22, 0, 0, 1, 0, 0);
    v[14] = mk(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[15] = mk(9, 0, 1, 9, 1, 9, 32'h99, 0, 0, 0, 32'h99, 0, 0, 0, 0, 0);
    v[16] = mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0, 1, 0, 0, 0);
    v[17] = mk(10, 0, 0, 0, 1, 10, 32'h5, 0, 0, 0, 32'h5, 0, 0, 0, 0, 0);
    v[18] = mk(10, 0, 1, 4, 0, 0, 0, 0, 0, 0, 32'h5, 0, 0, 0, 0, 32'h5);
    drive(idle);
    bus.rs1_addr = 5; bus.rs2_addr = 10;
    repeat (2) @(posedge clk);
    #2 check_all("reset", idle);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) begin
      drive(v[i]);
      #1 check_all($sformatf("vec%0d", i), v[i]);
      if (v[i].chk_nb) begin
        check($sformatf("vec%0d nb rs1_value", i), nb.rs1_value, v[i].e_nb_rs1v);
        check($sformatf("vec%0d nb stall", i), 32'(nb.stall), 32'(v[i].e_nb_stall));
      end
      @(posedge clk); #1;
    end
    drive(idle);
    bus.rs1_addr = 4; bus.rs2_addr = 10;
    #1 check("pre-rst rs1_busy x4", 32'(bus.rs1_busy), 1);
    check("pre-rst a0_value", bus.a0_value, 32'h5);
    check("pre-rst rs2_value x10", bus.rs2_value, 32'h5);
    rst = 1; bus.issue_valid = 1; bus.issue_rd = 4;
    #1 check("rst a0_value", bus.a0_value, 0);
    check("rst rs1_busy x4", 32'(bus.rs1_busy), 0);
    check("rst rs2_value x10", bus.rs2_value, 0);
    check("rst stall", 32'(bus.stall), 0);
    bus.issue_valid = 0;
    #1 rst = 0;
    @(posedge clk); #1;
    check("post-rst rs1_busy x4", 32'(bus.rs1_busy), 0);
    check("post-rst a0_value", bus.a0_value, 0);
    bus.rs1_addr = 5;
    #1 check("post-rst rs1_value x5", bus.rs1_value, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter ADDR_W, default 5, register index width; the file holds 2^ADDR_W entries, minimum ADDR_W 4.
REQ-002 SHALL provide parameter DATA_W, default 32, register data width.
REQ-003 SHALL provide parameter BYPASS, default 1, where 1 enables write-to-read forwarding and same-cycle busy release.
REQ-004 SHALL provide port clk, input, 1 bit, the single clock, with all state updating on its rising edge.
REQ-005 SHALL provide port rst, input, 1 bit, a reset that is asynchronous and active-high.
REQ-006 SHALL provide ports rs1_addr and rs2_addr, inputs, ADDR_W bits each, the read port indices.
REQ-007 SHALL provide ports rs1_value and rs2_value, outputs, DATA_W bits each, the read data.
REQ-008 SHALL provide ports rs1_busy and rs2_busy, outputs, 1 bit each, flagging that the source has a pending write.
REQ-009 SHALL provide ports issue_valid (input, 1 bit) and issue_rd (input, ADDR_W bits), an instruction issue that reserves destination issue_rd.
REQ-010 SHALL provide port stall, output, 1 bit, meaning the issue is refused this cycle.
REQ-011 SHALL provide ports wb0_en (1 bit), wb0_addr (ADDR_W bits) and wb0_data (DATA_W bits), all inputs, forming the ALU write-back port.
REQ-012 SHALL provide ports wb1_en (1 bit), wb1_addr (ADDR_W bits) and wb1_data (DATA_W bits), all inputs, forming the load write-back port.
REQ-013 SHALL provide port a0_value, output, DATA_W bits, the stored contents of register 10.

Function
REQ-014 SHALL hardwire register 0: it always reads 0, writes to it are dropped, and it is never busy.
REQ-015 SHALL, on a rising edge, write wbN_data to wbN_addr when wbN_en=1 and the address is nonzero.
REQ-016 SHALL, when wb0 and wb1 target the same register in the same cycle, store wb1_data.
REQ-017 SHALL make reads combinational; with BYPASS=1, a read whose address matches an enabled nonzero write-back returns that write data, with wb1 taking priority over wb0.
REQ-018 SHALL make reads with BYPASS=0 return the stored value only, so a value written at edge N is visible after edge N.
REQ-019 SHALL keep one busy bit per register.
REQ-020 SHALL raise stall combinationally when issue_valid=1 and any of busy[rs1_addr], busy[rs2_addr] or busy[issue_rd] is effectively set (WAW protection).
REQ-021 SHALL define "effectively set" as the stored busy bit, except that with BYPASS=1 it is 0 when a write-back to that register is enabled in the same cycle.
REQ-022 SHALL drive rsN_busy as effectively-set busy of rsN_addr, independent of issue_valid.
REQ-023 SHALL set busy[issue_rd] at the edge when issue_valid=1, stall=0 and issue_rd!=0; a stalled issue SHALL change no state.
REQ-024 SHALL clear busy[wbN_addr] at the edge when wbN_en=1.
REQ-025 SHALL give set priority over clear when a set and a clear of the same register occur in one cycle.
REQ-026 SHALL write a register that is not busy when a write-back targets it, without error flagging.
REQ-027 SHALL take a0_value from the stored register 10 with no bypass.

Reset
REQ-028 SHALL, while rst=1, immediately clear all registers and all busy bits, independent of clk.
REQ-029 SHALL hold rs1_value, rs2_value, a0_value, rs1_busy, rs2_busy and stall at 0 during reset, given that write-back enables are low.
REQ-030 SHALL abort any pending writes on reset asserted mid-operation, leaving no busy bits set after release.

Verification
REQ-031 SHALL verify write then read: wb0 writes x5=0x1234 at edge 1, then rs1_addr=5 gives 0x1234; with BYPASS=1 the value is also visible in the write cycle.
REQ-032 SHALL verify the x0 rule: wb1 writes x0=0xFFFFFFFF, then rs1_value=0, and an issue_rd=0 leaves stall=0 on the next issue of rs1=0.
REQ-033 SHALL verify scoreboarding: issue rd=7, then issue rs2=7 gives stall=1, rs2_busy=1; wb1 x7=0xAA with BYPASS=1 gives stall=0 and rs2_value=0xAA that cycle.
REQ-034 SHALL verify dual-write collision: wb0 writes x3=0x11 and wb1 writes x3=0x22 together, then x3 reads 0x22 and busy[3]=0.
REQ-035 SHALL verify set-over-clear: x9 busy, wb0 x9 plus an issue with rd=9 in the same cycle, then busy[9]=1 after the edge.
REQ-036 SHALL verify mid-operation reset: with x10=5 and busy[4]=1, rst pulsed between edges gives a0_value=0 and rs1_busy=0 for x4 immediately.
